// File: rtl/keystream_arbiter_ctrl.sv
// rtl/keystream_arbiter_ctrl.sv - shared LFSR keystream with round-robin block arbitration
module keystream_arbiter_ctrl #(
    parameter int               WIDTH  = 64,
    parameter int               WARMUP = 16,
    parameter logic [WIDTH-1:0] SEED   = 64'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP);
    localparam logic [CW-1:0] WARM_PRE  = CW'(WARMUP - 1);

    typedef enum logic {WARM, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_nxt;
    logic [CW-1:0]    warm_cnt, warm_cnt_nxt;
    logic             rr_ptr;
    logic             slot_free;
    logic             accept;
    logic             winner;
    logic [WIDTH-1:0] sel_data;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WARM;
            lfsr     <= SEED;
            warm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lfsr     <= lfsr_nxt;
            warm_cnt <= warm_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lfsr_nxt     = lfsr;
        warm_cnt_nxt = warm_cnt;

        // seed_load suppresses the grant so no keystream word is spent on a discarded result
        slot_free = (state == RUN) && !seed_load && (!out_valid || out_ready);
        winner    = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        accept    = slot_free && (req0_valid || req1_valid);
        req0_ready = accept && !winner;
        req1_ready = accept && winner;
        sel_data   = winner ? req1_data : req0_data;

        if (seed_load) begin
            lfsr_nxt     = (seed_val == '0) ? SEED : seed_val;
            warm_cnt_nxt = '0;
            state_nxt    = WARM;
        end else begin
            case (state)
                WARM: begin
                    if (warm_cnt == WARM_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        lfsr_nxt     = lfsr_step(lfsr);
                        warm_cnt_nxt = warm_cnt + 1'b1;
                        if (warm_cnt == WARM_PRE) begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        lfsr_nxt = lfsr_step(lfsr);
                    end
                end
                default: state_nxt = WARM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
            rr_ptr    <= 1'b0;
        end else if (seed_load) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data ^ lfsr;
            out_id    <= winner;
            rr_ptr    <= !winner;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state == WARM);

endmodule

// File: tb/tb_keystream_arbiter_ctrl.sv
// tb/tb_keystream_arbiter_ctrl.sv - randomized check of keystream_arbiter_ctrl against a reference model
module tb_keystream_arbiter_ctrl;

    localparam logic [63:0] SEED = 64'hACE1_0001;
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [63:0] seed_val;
    logic        v0, v1, out_ready;
    logic [63:0] d0, d1;
    logic [1:0]  r0, r1, ov, oid, busy;
    logic [63:0] od [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    keystream_arbiter_ctrl #(.WIDTH(64), .WARMUP(0), .SEED(SEED)) u_w0 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_val(seed_val),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0[0]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_id(oid[0]),
        .out_ready(out_ready), .busy(busy[0]));

    keystream_arbiter_ctrl #(.WIDTH(64), .WARMUP(16), .SEED(SEED)) u_w16 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_val(seed_val),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0[1]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_id(oid[1]),
        .out_ready(out_ready), .busy(busy[1]));

    // Reference model: one entry per instance, warm-up length per instance
    int          m_warmup [2] = '{0, 16};
    bit          m_warm   [2];
    int          m_cnt    [2];
    logic [63:0] m_s      [2];
    logic [63:0] m_od     [2];
    bit          m_ov     [2];
    bit          m_oid    [2];
    bit          m_ptr    [2];
    bit          acc0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ks_next(input logic [63:0] s);
        return (s << 1) | 64'(^(s & TAPS));
    endfunction

    function automatic logic [63:0] ks_advance(input logic [63:0] s, input int n);
        logic [63:0] t = s;
        for (int k = 0; k < n; k++) t = ks_next(t);
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_warm[i] = 1; m_cnt[i] = 0; m_s[i] = SEED;
            m_ov[i] = 0; m_od[i] = '0; m_oid[i] = 0; m_ptr[i] = 0;
        end
    endtask

    task automatic model_grant(input int i, output bit acc, output bit w);
        bit free;
        free = !m_warm[i] && !seed_load && (!m_ov[i] || out_ready);
        acc  = free && (v0 || v1);
        if (v0 && v1) w = m_ptr[i];
        else          w = v1;
    endtask

    // One clock: compare outputs before the edge, then advance the model across it
    task automatic cycle();
        bit acc [2];
        bit w   [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            model_grant(i, acc[i], w[i]);
            check($sformatf("ready0_%0d", i), 64'(r0[i]), 64'(acc[i] && !w[i]));
            check($sformatf("ready1_%0d", i), 64'(r1[i]), 64'(acc[i] && w[i]));
            check($sformatf("busy_%0d", i),   64'(busy[i]), 64'(m_warm[i]));
            check($sformatf("valid_%0d", i),  64'(ov[i]), 64'(m_ov[i]));
            check($sformatf("data_%0d", i),   od[i], m_od[i]);
            check($sformatf("id_%0d", i),     64'(oid[i]), 64'(m_oid[i]));
        end
        acc0 = r0[0] && v0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (seed_load) begin
                m_s[i] = (seed_val == 0) ? SEED : seed_val;
                m_warm[i] = 1; m_cnt[i] = 0; m_ov[i] = 0;
            end else if (m_warm[i]) begin
                if (m_cnt[i] == m_warmup[i]) m_warm[i] = 0;
                else begin
                    m_s[i] = ks_next(m_s[i]);
                    m_cnt[i]++;
                    if (m_cnt[i] == m_warmup[i]) m_warm[i] = 0;
                end
            end else begin
                if (m_ov[i] && out_ready) m_ov[i] = 0;
                if (acc[i]) begin
                    m_od[i] = (w[i] ? d1 : d0) ^ m_s[i];
                    m_oid[i] = w[i]; m_ov[i] = 1; m_ptr[i] = !w[i];
                    m_s[i] = ks_next(m_s[i]);
                end
            end
        end
        #1;
    endtask

    logic [63:0] exp_ks [4] = '{64'd1, 64'd2, 64'd4, 64'd8};
    logic [63:0] plain  [8];
    logic [63:0] cipher [$];
    logic [63:0] held, key, first16;
    int          nbusy, idx, budget;
    bit          got16;

    initial begin
        rst = 1; seed_load = 0; seed_val = '0; v0 = 0; v1 = 0; d0 = '0; d1 = '0; out_ready = 0;
        #12;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_valid_%0d", i), 64'(ov[i]), 64'd0);
            check($sformatf("rst_data_%0d", i),  od[i], 64'd0);
            check($sformatf("rst_busy_%0d", i),  64'(busy[i]), 64'd1);
            check($sformatf("rst_ready_%0d", i), 64'(r0[i] | r1[i]), 64'd0);
        end
        model_reset();
        rst = 0;

        // Both requesters valid: alternate grants, keystream 1,2,4,8
        seed_load = 1; seed_val = 64'd1; cycle(); seed_load = 0;
        v0 = 1; v1 = 1; out_ready = 1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("alt_data_%0d", k), od[0], exp_ks[k]);
            check($sformatf("alt_id_%0d", k), 64'(oid[0]), 64'(k % 2));
        end
        v1 = 0;

        // Single requester after reload: 1 then 2
        seed_load = 1; seed_val = 64'd1; cycle(); seed_load = 0;
        cycle(); cycle();
        check("single_first", od[0], 64'd1);
        check("single_id", 64'(oid[0]), 64'd0);
        cycle();
        check("single_second", od[0], 64'd2);

        // Backpressure: result held, no accepts, then resume
        v1 = 1; d0 = 64'h1234; d1 = 64'h5678; out_ready = 0;
        cycle();
        held = od[0];
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("hold_data_%0d", k), od[0], held);
        end
        out_ready = 1;
        for (int k = 0; k < 3; k++) cycle();
        v1 = 0;

        // Zero seed falls back to SEED; 16-step warm-up on the second instance
        d0 = '0; seed_load = 1; seed_val = '0; cycle(); seed_load = 0;
        nbusy = 0; got16 = 0; first16 = '0;
        for (int k = 0; k < 20; k++) begin
            if (busy[1]) nbusy++;
            cycle();
            if (!got16 && ov[1]) begin got16 = 1; first16 = od[1]; end
        end
        check("warm_busy_clks", 64'(nbusy), 64'd16);
        check("warm_first_word", first16, ks_advance(SEED, 16));

        // seed_load with a pending result and a valid request
        out_ready = 0; cycle();
        seed_load = 1; seed_val = 64'(1 + $urandom_range(1000));
        #1;
        check("load_blocks_ready", 64'(r0[0]), 64'd0);
        cycle(); seed_load = 0;
        check("load_clears_valid", 64'(ov[0]), 64'd0);
        out_ready = 1; v0 = 0;
        for (int k = 0; k < 18; k++) cycle();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
            out_ready = ($urandom_range(3) != 0);
            seed_load = ($urandom_range(40) == 0);
            seed_val = ($urandom_range(3) == 0) ? 64'd0 : {$urandom, $urandom};
            cycle();
        end
        seed_load = 0;

        // Asynchronous reset in the middle of a clock
        v0 = 1; out_ready = 1; cycle(); cycle();
        #2; rst = 1; #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("arst_valid_%0d", i), 64'(ov[i]), 64'd0);
            check($sformatf("arst_data_%0d", i),  od[i], 64'd0);
            check($sformatf("arst_busy_%0d", i),  64'(busy[i]), 64'd1);
            check($sformatf("arst_ready_%0d", i), 64'(r0[i]), 64'd0);
        end
        model_reset();
        #1; rst = 0;

        // Encrypt then decrypt with the same seed recovers the plaintext
        key = {$urandom, $urandom} | 64'd1;
        for (int k = 0; k < 8; k++) plain[k] = {$urandom, $urandom};
        v1 = 0; v0 = 0; seed_load = 1; seed_val = key; cycle(); seed_load = 0;
        v0 = 1; idx = 0; budget = 40;
        while (idx < 8 && budget > 0) begin
            d0 = plain[idx]; cycle(); budget--;
            if (acc0) begin cipher.push_back(od[0]); idx++; end
        end
        check("enc_count", 64'(idx), 64'd8);
        v0 = 0; seed_load = 1; seed_val = key; cycle(); seed_load = 0;
        v0 = 1; idx = 0; budget = 40;
        while (idx < cipher.size() && budget > 0) begin
            d0 = cipher[idx]; cycle(); budget--;
            if (acc0) begin
                check($sformatf("decrypt_%0d", idx), od[0], plain[idx]);
                idx++;
            end
        end
        check("dec_count", 64'(idx), 64'd8);
        v0 = 0; cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
